// File: rtl/cma_update_ctrl_pkg.sv
// Shared types and helpers for the CMA coefficient update controller.
// CMA_UPDATE_CTRL_COEFF_SAT_EN selects saturating (defined) or wrapping (undefined) tap narrowing.
package cma_update_ctrl_pkg;

  localparam int CMA_FIR_LEN       = 21;
  localparam int CMA_NB_COEFF      = 8;
  localparam int CMA_NBF_COEFF     = 7;
  localparam int CMA_NB_GUARD      = 4;
  localparam int CMA_UPDATE_PERIOD = 64;

`ifdef CMA_UPDATE_CTRL_COEFF_SAT_EN
  localparam bit COEFF_SAT = 1'b1;
`else
  localparam bit COEFF_SAT = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_COLLECT = 2'd2,
    ST_COMMIT  = 2'd3
  } cma_state_e;

  // Largest positive value in S(nb, nbf) with nbf = nb-1, i.e. "almost 1.0".
  function automatic logic [31:0] coeff_one(input int unsigned nbf);
    return (32'd1 << nbf) - 32'd1;
  endfunction

  // Caller keeps the low nb bits; with sat clear that is a plain two's-complement wrap.
  function automatic logic signed [31:0] coeff_narrow(input logic signed [31:0] v,
                                                      input int unsigned nb,
                                                      input bit sat);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (nb - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (nb - 1));
    if (sat && (v > hi)) return hi;
    if (sat && (v < lo)) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cma_period_counter.sv
// Enable-gated symbol counter; o_tick is combinational in the cycle of the wrapping symbol.
// No backpressure: symbols are counted whenever adaptation is enabled.
module cma_period_counter #(
  parameter int UPDATE_PERIOD = 64
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_adapt_en,
  input  logic i_sym_valid,
  output logic o_tick
);

  localparam int CW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(UPDATE_PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (i_adapt_en && i_sym_valid) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = tick;

endmodule

// File: rtl/cma_update_ctrl.sv
// Collects a serial CMA weight set into a shadow buffer and commits it atomically (strobe 1 cycle after last tap).
// Taps are accepted only while collecting; CMA_UPDATE_CTRL_COEFF_SAT_EN enables saturating narrowing.
module cma_update_ctrl
  import cma_update_ctrl_pkg::*;
#(
  parameter int FIR_LEN       = CMA_FIR_LEN,
  parameter int NB_COEFF      = CMA_NB_COEFF,
  parameter int NBF_COEFF     = CMA_NBF_COEFF,
  parameter int NB_GUARD      = CMA_NB_GUARD,
  parameter int UPDATE_PERIOD = CMA_UPDATE_PERIOD,
  parameter int CENTRAL_TAP   = FIR_LEN / 2
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_adapt_en,
  input  logic                         i_sym_valid,
  output logic                         o_cma_start,
  input  logic                         i_tap_valid,
  input  logic [NB_COEFF+NB_GUARD-1:0] i_tap_data,
  output logic                         o_tap_ready,
  output logic                         o_update_en,
  output logic [FIR_LEN*NB_COEFF-1:0]  o_w_new_flat,
  output logic                         o_busy,
  output logic                         o_overrun
);

  localparam int IW = (FIR_LEN > 1) ? $clog2(FIR_LEN) : 1;
  localparam logic [IW-1:0]       LAST_IDX  = IW'(FIR_LEN - 1);
  localparam logic [NB_COEFF-1:0] COEFF_RST = NB_COEFF'(coeff_one(NBF_COEFF));

  function automatic logic [FIR_LEN*NB_COEFF-1:0] reset_flat();
    logic [FIR_LEN*NB_COEFF-1:0] f;
    f = '0;
    f[CENTRAL_TAP*NB_COEFF +: NB_COEFF] = COEFF_RST;
    return f;
  endfunction

  localparam logic [FIR_LEN*NB_COEFF-1:0] W_RST = reset_flat();

  cma_state_e                  state_q;
  logic [IW-1:0]               idx_q;
  logic [NB_COEFF-1:0]         shadow_q [FIR_LEN];
  logic [NB_COEFF-1:0]         shadow_d [FIR_LEN];
  logic [FIR_LEN*NB_COEFF-1:0] shadow_flat_d;
  logic [FIR_LEN*NB_COEFF-1:0] w_q;
  logic                        cma_start_q;
  logic                        tap_ready_q;
  logic                        update_en_q;
  logic                        overrun_q;

  logic                period_tick;
  logic                tap_accept;
  logic                abort;
  logic                last_beat;
  logic [NB_COEFF-1:0] tap_nar;

  cma_period_counter #(
    .UPDATE_PERIOD (UPDATE_PERIOD)
  ) u_period (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_adapt_en  (i_adapt_en),
    .i_sym_valid (i_sym_valid),
    .o_tick      (period_tick)
  );

  assign tap_nar    = NB_COEFF'(coeff_narrow(32'(signed'(i_tap_data)), NB_COEFF, COEFF_SAT));
  assign abort      = ((state_q == ST_REQ) || (state_q == ST_COLLECT)) && !i_adapt_en;
  assign tap_accept = (state_q == ST_COLLECT) && tap_ready_q && i_tap_valid && !abort;
  assign last_beat  = tap_accept && (idx_q == LAST_IDX);

  // An abort restores the shadow to the live set so a later partial write cannot leak old taps.
  always_comb begin
    shadow_d = shadow_q;
    if (abort) begin
      for (int k = 0; k < FIR_LEN; k++) begin
        shadow_d[k] = w_q[k*NB_COEFF +: NB_COEFF];
      end
    end else if (tap_accept) begin
      shadow_d[idx_q] = tap_nar;
    end
  end

  always_comb begin
    shadow_flat_d = '0;
    for (int k = 0; k < FIR_LEN; k++) begin
      shadow_flat_d[k*NB_COEFF +: NB_COEFF] = shadow_d[k];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cma_start_q <= 1'b0;
      tap_ready_q <= 1'b0;
      update_en_q <= 1'b0;
      overrun_q   <= 1'b0;
      w_q         <= W_RST;
      for (int k = 0; k < FIR_LEN; k++) begin
        shadow_q[k] <= (k == CENTRAL_TAP) ? COEFF_RST : '0;
      end
    end else begin
      shadow_q    <= shadow_d;
      cma_start_q <= 1'b0;
      update_en_q <= 1'b0;
      // Requests arriving while busy are dropped, only flagged.
      if (period_tick && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (period_tick) begin
            state_q     <= ST_REQ;
            cma_start_q <= 1'b1;
          end
        end
        ST_REQ: begin
          idx_q <= '0;
          if (abort) begin
            state_q <= ST_IDLE;
          end else begin
            state_q     <= ST_COLLECT;
            tap_ready_q <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (abort) begin
            state_q     <= ST_IDLE;
            tap_ready_q <= 1'b0;
          end else if (tap_accept) begin
            idx_q <= idx_q + IW'(1);
            if (last_beat) begin
              state_q     <= ST_COMMIT;
              tap_ready_q <= 1'b0;
              update_en_q <= 1'b1;
              w_q         <= shadow_flat_d;
            end
          end
        end
        ST_COMMIT: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cma_start  = cma_start_q;
  assign o_tap_ready  = tap_ready_q;
  assign o_update_en  = update_en_q;
  assign o_w_new_flat = w_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_overrun    = overrun_q;

endmodule
